uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 15 +
 rtl/rx_sync.sv | 26 ++
 rtl/uart_receiver.sv | 178 +++++++++++++++++
 tb/tb_uart_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and receiver state encoding shared by the UART receive and transmit paths.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level
// so that releasing reset never looks like a start bit.
module rx_sync (
  input  logic BCLK,
  input  logic RST,
  input  logic line_raw,
  output logic line_sync
);

  logic meta_r;
  logic sync_r;

  // Capture stage followed by resolution stage.
  always_ff @(posedge BCLK or negedge RST) begin
    if (!RST) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= line_raw;
      sync_r <= meta_r;
    end
  end

  assign line_sync = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first data shift,
// stop-bit check, and a one-byte holding register with ready/framing/overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 BCLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 rsr_busy
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [SAMP_W-1:0] SAMP_ZERO = {SAMP_W{1'b0}};
  localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1'b1);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1'b1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS);

  logic                 rx_s;
  rx_state_e            state_r;
  rx_state_e            state_nx_s;
  logic [SAMP_W-1:0]    samp_cnt_r;
  logic [SAMP_W-1:0]    samp_cnt_nx_s;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_nx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nx_s;
  logic                 load_s;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_ready_r;
  logic                 framing_err_r;
  logic                 overrun_err_r;
  logic                 rsr_busy_r;

  rx_sync u_rx_sync (
    .BCLK      (BCLK),
    .RST       (RST),
    .line_raw  (RX_IN),
    .line_sync (rx_s)
  );

  // Next-state, counter and shift-register logic of the receive FSM.
  always_comb begin
    state_nx_s    = state_r;
    samp_cnt_nx_s = samp_cnt_r;
    bit_cnt_nx_s  = bit_cnt_r;
    shift_nx_s    = shift_r;
    load_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nx_s    = ST_START;
          samp_cnt_nx_s = SAMP_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (samp_cnt_r == SAMP_MID) begin
          samp_cnt_nx_s = SAMP_ZERO;
          bit_cnt_nx_s  = BIT_ZERO;
          if (rx_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DATA;
          end
        end else begin
          samp_cnt_nx_s = samp_cnt_r + SAMP_ONE;
        end
      end
      ST_DATA: begin
        // The bit counter reaching DATA_BITS costs one extra cycle before STOP starts counting.
        if (bit_cnt_r == BIT_LAST) begin
          state_nx_s    = ST_STOP;
          samp_cnt_nx_s = SAMP_ZERO;
          bit_cnt_nx_s  = BIT_ZERO;
        end else if (samp_cnt_r == SAMP_LAST) begin
          shift_nx_s    = {rx_s, shift_r[DATA_BITS-1:1]};
          samp_cnt_nx_s = SAMP_ZERO;
          bit_cnt_nx_s  = bit_cnt_r + BIT_ONE;
        end else begin
          samp_cnt_nx_s = samp_cnt_r + SAMP_ONE;
        end
      end
      ST_STOP: begin
        if (samp_cnt_r == SAMP_LAST) begin
          load_s        = 1'b1;
          samp_cnt_nx_s = SAMP_ZERO;
          if (rx_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_WAIT_HIGH;
          end
        end else begin
          samp_cnt_nx_s = samp_cnt_r + SAMP_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        samp_cnt_nx_s = SAMP_ZERO;
        bit_cnt_nx_s  = BIT_ZERO;
      end
    endcase
  end

  // FSM state, counters and shift register.
  always_ff @(posedge BCLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      samp_cnt_r <= SAMP_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      samp_cnt_r <= samp_cnt_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      shift_r    <= shift_nx_s;
    end
  end

  // Holding register and status flags; a load takes priority over a same-cycle acknowledge.
  always_ff @(posedge BCLK or negedge RST) begin
    if (!RST) begin
      rx_data_r     <= {DATA_BITS{1'b0}};
      rx_ready_r    <= 1'b0;
      framing_err_r <= 1'b0;
      overrun_err_r <= 1'b0;
      rsr_busy_r    <= 1'b0;
    end else begin
      rsr_busy_r <= (state_nx_s != ST_IDLE);
      if (load_s) begin
        rx_data_r     <= shift_r;
        rx_ready_r    <= 1'b1;
        framing_err_r <= ~rx_s;
        if (rx_ready_r) begin
          overrun_err_r <= ~rd_ack;
        end else begin
          overrun_err_r <= overrun_err_r;
        end
      end else if (rd_ack && rx_ready_r) begin
        rx_ready_r    <= 1'b0;
        framing_err_r <= 1'b0;
        overrun_err_r <= 1'b0;
      end else begin
        rx_ready_r    <= rx_ready_r;
        framing_err_r <= framing_err_r;
        overrun_err_r <= overrun_err_r;
      end
    end
  end

  assign RX_DATA     = rx_data_r;
  assign rx_ready    = rx_ready_r;
  assign framing_err = framing_err_r;
  assign overrun_err = overrun_err_r;
  assign rsr_busy    = rsr_busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frame bench for uart_receiver with a frame-level reference model.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS  = OVERSAMPLE_DEF;
  localparam int DB  = DATA_BITS_DEF;
  localparam int LAT = OS / 2 + OS * (DB + 1) + 1;

  logic          BCLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          rd_ack = 1'b0;
  logic [DB-1:0] RX_DATA;
  logic          rx_ready;
  logic          framing_err;
  logic          overrun_err;
  logic          rsr_busy;

  int checks = 0;
  int failures = 0;

  logic [DB-1:0] m_data = '0;
  logic          m_ready = 1'b0;
  logic          m_ferr = 1'b0;
  logic          m_oerr = 1'b0;

  int   cyc = 0;
  int   busy_rise_t = 0;
  int   busy_fall_t = 0;
  int   ready_rise_t = 0;
  int   busy_rises = 0;
  int   ready_rises = 0;
  logic prev_busy = 1'b0;
  logic prev_ready = 1'b0;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .BCLK        (BCLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .rd_ack      (rd_ack),
    .RX_DATA     (RX_DATA),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .rsr_busy    (rsr_busy)
  );

  always #5 BCLK = ~BCLK;

  // Edge timestamps of rsr_busy and rx_ready, in clock cycles.
  always @(posedge BCLK) begin
    #2;
    cyc        <= cyc + 1;
    prev_busy  <= rsr_busy;
    prev_ready <= rx_ready;
    if (rsr_busy && !prev_busy) begin
      busy_rise_t <= cyc;
      busy_rises  <= busy_rises + 1;
    end
    if (!rsr_busy && prev_busy) busy_fall_t <= cyc;
    if (rx_ready && !prev_ready) begin
      ready_rise_t <= cyc;
      ready_rises  <= ready_rises + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"},  32'(RX_DATA),     32'(m_data));
    chk({tag, "_ready"}, 32'(rx_ready),    32'(m_ready));
    chk({tag, "_ferr"},  32'(framing_err), 32'(m_ferr));
    chk({tag, "_oerr"},  32'(overrun_err), 32'(m_oerr));
  endtask

  // Frame-level model: a completed frame lands in the holding register.
  task automatic model_load(input logic [DB-1:0] d, input logic stop, input logic ack_same);
    if (m_ready) m_oerr = !ack_same;
    m_ready = 1'b1;
    m_data  = d;
    m_ferr  = !stop;
  endtask

  task automatic model_ack();
    if (m_ready) begin
      m_ready = 1'b0;
      m_ferr  = 1'b0;
      m_oerr  = 1'b0;
    end
  endtask

  task automatic line_hold(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(negedge BCLK);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int extra_low, input int idle);
    line_hold(1'b0, OS);
    for (int i = 0; i < DB; i++) line_hold(d[i], OS);
    line_hold(stop, OS);
    if (!stop) line_hold(1'b0, extra_low);
    if (idle > 0) line_hold(1'b1, idle);
  endtask

  task automatic do_ack();
    rd_ack = 1'b1;
    @(negedge BCLK);
    rd_ack = 1'b0;
    model_ack();
    @(negedge BCLK);
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 4 * OS && !rsr_busy; i++) @(negedge BCLK);
    chk(tag, 32'(rsr_busy), 32'd1);
  endtask

  initial begin
    int            rr;
    int            br;
    logic [DB-1:0] d;
    logic          stop;
    logic          ack;
    logic          was_ready;

    repeat (3) @(negedge BCLK);
    check_outputs("reset");
    chk("reset_busy", 32'(rsr_busy), 32'd0);
    RST = 1'b1;
    repeat (4) @(negedge BCLK);
    chk("idle_busy", 32'(rsr_busy), 32'd0);

    // Clean 0x55 frame and its latency.
    send_frame(8'h55, 1'b1, 0, 8);
    model_load(8'h55, 1'b1, 1'b0);
    check_outputs("f55");
    chk("f55_lat", 32'(ready_rise_t - busy_rise_t), 32'(LAT));
    do_ack();
    check_outputs("f55_ack");

    // Short low glitch is rejected at mid start bit.
    br = busy_rises;
    rr = ready_rises;
    line_hold(1'b0, 4);
    line_hold(1'b1, 3 * OS);
    chk("glitch_rise", 32'(busy_rises), 32'(br + 1));
    chk("glitch_width", 32'(busy_fall_t - busy_rise_t), 32'(OS / 2));
    chk("glitch_busy", 32'(rsr_busy), 32'd0);
    chk("glitch_nobyte", 32'(ready_rises), 32'(rr));
    check_outputs("glitch");

    // Bad stop bit with line held low: one byte, busy until line returns high.
    rr = ready_rises;
    send_frame(8'hA3, 1'b0, 40, 0);
    model_load(8'hA3, 1'b0, 1'b0);
    check_outputs("brk_low");
    chk("brk_busy_low", 32'(rsr_busy), 32'd1);
    line_hold(1'b1, 3 * OS);
    chk("brk_busy_high", 32'(rsr_busy), 32'd0);
    chk("brk_one_byte", 32'(ready_rises), 32'(rr + 1));
    check_outputs("brk_high");
    do_ack();
    check_outputs("brk_ack");

    // Overrun: two frames without acknowledge.
    send_frame(8'h12, 1'b1, 0, 8);
    model_load(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 0, 8);
    model_load(8'h34, 1'b1, 1'b0);
    check_outputs("ovr");
    do_ack();
    check_outputs("ovr_ack");

    // Acknowledge coincident with the second load.
    send_frame(8'h12, 1'b1, 0, 8);
    model_load(8'h12, 1'b1, 1'b0);
    fork
      send_frame(8'h34, 1'b1, 0, 8);
      begin
        wait_busy("coin_busy");
        repeat (LAT - 1) @(negedge BCLK);
        rd_ack = 1'b1;
        @(negedge BCLK);
        rd_ack = 1'b0;
      end
    join
    model_load(8'h34, 1'b1, 1'b1);
    check_outputs("coin");
    do_ack();

    // Asynchronous reset in the middle of data bit 4 of 0xFF.
    send_frame(8'h5A, 1'b1, 0, 8);
    model_load(8'h5A, 1'b1, 1'b0);
    check_outputs("pre_rst");
    fork
      send_frame(8'hFF, 1'b1, 0, 8);
      begin
        wait_busy("rst_busy");
        repeat (OS / 2 + OS * 4 + OS / 2) @(negedge BCLK);
        RST = 1'b0;
        #1;
        m_data  = '0;
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
        check_outputs("rst_now");
        chk("rst_now_busy", 32'(rsr_busy), 32'd0);
        repeat (3) @(negedge BCLK);
        RST = 1'b1;
      end
    join
    rr = ready_rises;
    repeat (2 * OS) @(negedge BCLK);
    chk("post_rst_busy", 32'(rsr_busy), 32'd0);
    chk("post_rst_nobyte", 32'(ready_rises), 32'(rr));
    send_frame(8'h0F, 1'b1, 0, 8);
    model_load(8'h0F, 1'b1, 1'b0);
    check_outputs("f0f");
    chk("f0f_lat", 32'(ready_rise_t - busy_rise_t), 32'(LAT));
    do_ack();

    // Randomized frames, stop bits and acknowledges.
    for (int k = 0; k < 10; k++) begin
      d         = DB'($urandom);
      stop      = ($urandom_range(0, 3) != 0);
      ack       = 1'($urandom_range(0, 1));
      was_ready = m_ready;
      send_frame(d, stop, int'($urandom_range(1, 30)), 8);
      model_load(d, stop, 1'b0);
      check_outputs("rnd");
      if (!was_ready) chk("rnd_lat", 32'(ready_rise_t - busy_rise_t), 32'(LAT));
      chk("rnd_idle", 32'(rsr_busy), 32'd0);
      if (ack) begin
        do_ack();
        check_outputs("rnd_ack");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
